fetch_queue: RTL and testbench

//  Instruction-fetch stage between the PC register and decode in the RISC-V core.
//  - Drives D and ClockEnable of the PC register: the next-PC value and the PC advance enable.
//  - Captures {PC, instruction} pairs from the PC register output and the instruction ROM into a small FIFO.
//  - Presents the FIFO head to decode with a valid/ready handshake.
//  - Handles redirects (branch/jump flush) and a sticky halt (ecall).

---
 rtl/fetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction-fetch stage: next-PC generation and {PC, instruction} FIFO to decode
//
// Purpose: drives the PC register (next_pc_o / pc_enable_o), captures {pc_in_i, instr_in_i}
// pairs into a small FIFO, presents the head to decode with valid/ready, and handles
// redirect (flush + PC load) and a sticky halt.
//
// Ports:
//   clk_i               rising-edge clock
//   rst_i               synchronous active-high reset
//   pc_in_i             current PC from the PC register Q
//   instr_in_i          ROM word at pc_in_i (combinational, same cycle)
//   redirect_i          flush queue and load redirect_target_i into the PC
//   redirect_target_i   new PC on redirect
//   halt_i              enter HALTED (ecall from decode)
//   next_pc_o           PC register D
//   pc_enable_o         PC register clock enable
//   out_valid_o         FIFO head valid
//   out_pc_o            PC of head entry (0 when empty)
//   out_instr_o         instruction of head entry (0 when empty)
//   out_ready_i         decode accepts the head this cycle
//   halted_o            state is HALTED
//   fetch_count_o       number of pushes, wraps modulo 2^32
module fetch_queue #(
  parameter int NrOfBits = 32,
  parameter int Depth    = 2,
  parameter int PcStep   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NrOfBits-1:0] pc_in_i,
  input  logic [NrOfBits-1:0] instr_in_i,
  input  logic                redirect_i,
  input  logic [NrOfBits-1:0] redirect_target_i,
  input  logic                halt_i,
  output logic [NrOfBits-1:0] next_pc_o,
  output logic                pc_enable_o,
  output logic                out_valid_o,
  output logic [NrOfBits-1:0] out_pc_o,
  output logic [NrOfBits-1:0] out_instr_o,
  input  logic                out_ready_i,
  output logic                halted_o,
  output logic [31:0]         fetch_count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [31:0]         fetch_count_q, fetch_count_d;
  logic [NrOfBits-1:0] pc_mem_q    [Depth];
  logic [NrOfBits-1:0] instr_mem_q [Depth];

  logic running;
  logic pop;
  logic flush;
  logic fetch;

  assign running = (state_q == ST_RUN);
  assign pop     = out_valid_o & out_ready_i;
  // Redirect only acts while running; in HALTED it is ignored entirely.
  assign flush   = running & redirect_i;
  // A simultaneous pop frees a slot, so a full queue can still accept a push.
  assign fetch   = running & ~halt_i & ~redirect_i
                 & ((count_q < CntW'(Depth)) | pop);

  assign next_pc_o   = redirect_i ? redirect_target_i : pc_in_i + NrOfBits'(PcStep);
  assign pc_enable_o = ~rst_i & (flush | fetch);

  assign out_valid_o   = (count_q != '0);
  assign out_pc_o      = out_valid_o ? pc_mem_q[rd_ptr_q]    : '0;
  assign out_instr_o   = out_valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign halted_o      = (state_q == ST_HALTED);
  assign fetch_count_o = fetch_count_q;

  always_comb begin
    state_d = state_q;
    if (running && halt_i) begin
      state_d = ST_HALTED;
    end
  end

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q;
    if (flush) begin
      // A pop in the redirect cycle is discarded along with the rest of the queue.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (fetch) begin
        wr_ptr_d      = wr_ptr_q + 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
      case ({fetch, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Storage needs no reset: outputs are masked to zero while the queue is empty.
  always_ff @(posedge clk_i) begin
    if (fetch && !rst_i) begin
      pc_mem_q[wr_ptr_q]    <= pc_in_i;
      instr_mem_q[wr_ptr_q] <= instr_in_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue with a PC register and ROM model
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt;
  logic [31:0] next_pc;
  logic        pc_enable;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        halted;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.NrOfBits(32), .Depth(2), .PcStep(4)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .pc_in_i           (pc),
    .instr_in_i        (instr),
    .redirect_i        (redirect),
    .redirect_target_i (redirect_target),
    .halt_i            (halt),
    .next_pc_o         (next_pc),
    .pc_enable_o       (pc_enable),
    .out_valid_o       (out_valid),
    .out_pc_o          (out_pc),
    .out_instr_o       (out_instr),
    .out_ready_i       (out_ready),
    .halted_o          (halted),
    .fetch_count_o     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register and ROM surrounding the fetch stage.
  always @(posedge clk) begin
    if (rst) pc <= 32'h0;
    else if (pc_enable) pc <= next_pc;
  end
  assign instr = 32'h13 | (pc << 8);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_target = 32'h0; halt = 1'b0; out_ready = 1'b1;
    pc = 32'h0;

    // 1: reset state and streaming fetch
    step();
    check("rst_pc_enable", {31'b0, pc_enable}, 32'd0);
    check("rst_next_pc", next_pc, 32'd4);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    rst = 1'b0;
    #1;
    check("t1_pc_enable0", {31'b0, pc_enable}, 32'd1);
    check("t1_next_pc0", next_pc, 32'd4);
    step();
    check("t1_valid1", {31'b0, out_valid}, 32'd1);
    check("t1_out_pc1", out_pc, 32'd0);
    check("t1_out_instr1", out_instr, 32'h13);
    check("t1_pc_enable1", {31'b0, pc_enable}, 32'd1);
    check("t1_next_pc1", next_pc, 32'd8);
    step();
    check("t1_out_pc2", out_pc, 32'd4);
    check("t1_out_instr2", out_instr, 32'h413);
    check("t1_next_pc2", next_pc, 32'd12);
    check("t1_fetch_count", fetch_count, 32'd2);

    // 2: backpressure fills the queue, then simultaneous pop and push
    do_reset();
    out_ready = 1'b0;
    step();
    step();
    check("t2_full_pc_enable", {31'b0, pc_enable}, 32'd0);
    check("t2_full_pc", pc, 32'd8);
    step();
    check("t2_hold_pc", pc, 32'd8);
    check("t2_hold_out_pc", out_pc, 32'd0);
    check("t2_hold_count", fetch_count, 32'd2);
    out_ready = 1'b1;
    #1;
    check("t2_poppush_enable", {31'b0, pc_enable}, 32'd1);
    step();
    out_ready = 1'b0;
    #1;
    check("t2_fetch_count3", fetch_count, 32'd3);
    check("t2_head_pc", out_pc, 32'd4);
    check("t2_still_full", {31'b0, pc_enable}, 32'd0);

    // 3: redirect on a full queue
    do_reset();
    out_ready = 1'b0;
    step();
    step();
    redirect = 1'b1; redirect_target = 32'h100;
    #1;
    check("t3_next_pc", next_pc, 32'h100);
    check("t3_pc_enable", {31'b0, pc_enable}, 32'd1);
    step();
    redirect = 1'b0;
    #1;
    check("t3_flushed_valid", {31'b0, out_valid}, 32'd0);
    check("t3_flushed_out_pc", out_pc, 32'd0);
    step();
    check("t3_out_pc", out_pc, 32'h100);
    check("t3_out_instr", out_instr, 32'h10013);

    // 4: halt with two entries queued, drain, redirect ignored
    do_reset();
    out_ready = 1'b0;
    step();
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    #1;
    check("t4_halted", {31'b0, halted}, 32'd1);
    check("t4_pc_enable", {31'b0, pc_enable}, 32'd0);
    out_ready = 1'b1;
    #1;
    check("t4_drain0", out_pc, 32'd0);
    step();
    check("t4_drain1", out_pc, 32'd4);
    check("t4_drain_enable", {31'b0, pc_enable}, 32'd0);
    step();
    check("t4_empty", {31'b0, out_valid}, 32'd0);
    redirect = 1'b1; redirect_target = 32'h200;
    #1;
    check("t4_redir_enable", {31'b0, pc_enable}, 32'd0);
    step();
    redirect = 1'b0;
    #1;
    check("t4_redir_pc_held", pc, 32'd8);
    check("t4_redir_valid", {31'b0, out_valid}, 32'd0);
    check("t4_still_halted", {31'b0, halted}, 32'd1);

    // 5: reset while halted with a full queue
    do_reset();
    out_ready = 1'b0;
    step();
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_rst_enable", {31'b0, pc_enable}, 32'd0);
    check("t5_rst_next_pc", next_pc, 32'd12);
    step();
    rst = 1'b0;
    #1;
    check("t5_valid", {31'b0, out_valid}, 32'd0);
    check("t5_out_pc", out_pc, 32'd0);
    check("t5_halted", {31'b0, halted}, 32'd0);
    check("t5_fetch_count", fetch_count, 32'd0);
    check("t5_resume_enable", {31'b0, pc_enable}, 32'd1);
    step();
    check("t5_resume_valid", {31'b0, out_valid}, 32'd1);
    check("t5_resume_count", fetch_count, 32'd1);

    // 6: PC wrap at the top of the address space
    do_reset();
    out_ready = 1'b1;
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    #1;
    check("t6_pc_loaded", pc, 32'hFFFF_FFFC);
    check("t6_next_pc_wrap", next_pc, 32'h0);
    check("t6_pc_enable", {31'b0, pc_enable}, 32'd1);
    step();
    check("t6_out_pc", out_pc, 32'hFFFF_FFFC);
    check("t6_out_instr", out_instr, 32'hFFFF_FC13);
    check("t6_pc_wrapped", pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
